writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Producer side of the integer register file: merges ALU results and load-unit results into the register file's single write port.
- Drives the write enable, write address and write data ports of the register file.
- Buffers load results in a small FIFO; ALU results take priority.
- Keeps a 32-bit scoreboard of registers with an outstanding load, so decode can detect load-use hazards.

Parameters:
- LOAD_DEPTH, 2, load-result FIFO entries (power of two, >=2)
- XLEN, 32, data width

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- issue_valid  in  1  decode issues an instruction this cycle
- issue_is_load  in  1  issued instruction is a load
- issue_rd  in  5  destination of the issued instruction
- alu_valid  in  1  ALU result valid; no backpressure
- alu_rd  in  5  ALU destination
- alu_data  in  XLEN  ALU result
- load_valid  in  1  load result valid
- load_ready  out  1  FIFO can accept a load result
- load_rd  in  5  load destination
- load_data  in  XLEN  load result
- rf_write_enable  out  1  register file write enable (registered)
- rf_write_address  out  5  register file write address (registered)
- rf_write_data  out  XLEN  register file write data (registered)
- query_addr1, query_addr2  in  5 each  decode source registers
- query_busy1, query_busy2  out  1 each  source has a pending load (combinational)
- wb_stall_req  out  1  FIFO full; the core must hold ALU issue

Behaviour:
- Reset:
  - Clock is clk; reset is reset_n, synchronous and active-low: sampled only on the rising edge of clk, asserted when low.
  - Reset flushes the FIFO (count 0) and clears the scoreboard.
  - All rf_write_* outputs reset to 0.
  - load_ready is 1 and wb_stall_req is 0 in the first cycle after reset.
  - Reset mid-operation discards all buffered loads; it has priority over all other events.
- Load handshake:
  - A transfer occurs on an edge where load_valid && load_ready.
  - load_ready = !full (combinational from the FIFO count).
  - wb_stall_req = full.
- Selection at each edge:
  - If alu_valid, the ALU result is registered to the rf outputs.
  - Else, if the FIFO is non-empty, the head is popped and registered.
  - Else rf_write_enable goes to 0 at that edge.
- Latency:
  - ALU: 1 edge.
  - Load (without the optional feature): at least 2 edges (enqueue, then pop).
- rd = 0:
  - The entry is consumed or popped normally.
  - rf_write_enable stays 0; address and data are don't-care.
- Simultaneous push and pop on a full FIFO: allowed only when load_ready was high; full blocks the push even if a pop occurs in the same cycle.
- FIFO pointers wrap modulo LOAD_DEPTH.
- Scoreboard:
  - Set: on an edge with issue_valid && issue_is_load && issue_rd != 0, bit[issue_rd] is set.
  - Clear: bit[rd] is cleared when a load entry with that rd is popped.
  - Set and clear of the same rd on the same edge: set wins, because a newer load is outstanding.
  - Bit 0 is constant 0.
  - query_busyN = scoreboard[query_addrN].
- Output ordering: loads retire in FIFO order. An ALU write and a load write to the same rd are ordered by the core; this block does not reorder.

Optional Feature:
- Macro: WB_LOAD_BYPASS_EN.
- Defined:
  - A load transferred while the FIFO is empty and alu_valid is 0 is registered directly to the rf outputs.
  - Load latency is 1; the FIFO is not written.
  - Its scoreboard bit clears on that same edge; the set-wins rule still applies.
- Undefined: every load goes through the FIFO, with minimum latency 2.

Decomposition:
- Package rv32_wb_pkg:
  - XLEN = 32 and REG_ADDR_W = 5.
  - typedef wb_entry_t, a struct {rd, data}.
  - typedef scoreboard_t, 32 bits.
- Sub-module wb_fifo (parameterised depth, wb_entry_t payload, push/pop/full/empty/count, synchronous active-low reset) holds the load buffer.
- Arbitration and the scoreboard live in the top module.

Test Plan:
- ALU only:
  - Stimulus: alu_valid, rd = 5, data 0xDEADBEEF at edge k.
  - Response: rf_write_enable = 1, address 5, data 0xDEADBEEF after edge k; enable 0 after edge k+1 if idle.
- Load path:
  - Stimulus: issue load rd = 7; a later load transfer of rd 7, data 0x12345678 at edge k.
  - Response: query_busy1 (addr 7) = 1 until the pop; write appears after edge k+1 (after edge k with WB_LOAD_BYPASS_EN); busy 0 afterwards.
- Priority and full:
  - Stimulus: two loads buffered (rd 3, 4) while alu_valid is held 3 cycles.
  - Response: load_ready = 0 and wb_stall_req = 1 while full; ALU writes emitted first, then rd 3, then rd 4, in order.
- Set/clear collision:
  - Stimulus: a load for rd 9 pops on the same edge a new load to rd 9 issues.
  - Response: scoreboard bit 9 remains 1.
- rd = 0:
  - Stimulus: an ALU result and a load result, each with rd 0 and data 0xFFFFFFFF.
  - Response: rf_write_enable never asserts; the load is still popped; query_busy for addr 0 is always 0.
- Reset mid-operation:
  - Stimulus: FIFO holding 2 entries and scoreboard bits 3 and 4 set; reset_n low for 1 edge.
  - Response: after the edge, outputs are 0, load_ready = 1, busy bits are 0, and no stale write ever appears.

Source files
------------

// File: rtl/rv32_wb_pkg.sv
// Shared types for the integer writeback path.
// Register-file write entries and the load scoreboard.
package rv32_wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    typedef logic [31:0] scoreboard_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-result buffer for the writeback arbiter.
// Power-of-two depth, pointers wrap naturally; push is refused when full.
module wb_fifo
    import rv32_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage, no reset needed since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load results onto the single register-file write port.
// Optional WB_LOAD_BYPASS_EN lets a load skip an empty buffer when the ALU is idle.
module writeback_arbiter
    import rv32_wb_pkg::*;
#(
    parameter int LOAD_DEPTH = 2,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            issue_valid,
    input  logic            issue_is_load,
    input  logic [4:0]      issue_rd,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [4:0]      load_rd,
    input  logic [XLEN-1:0] load_data,
    output logic            rf_write_enable,
    output logic [4:0]      rf_write_address,
    output logic [XLEN-1:0] rf_write_data,
    input  logic [4:0]      query_addr1,
    input  logic [4:0]      query_addr2,
    output logic            query_busy1,
    output logic            query_busy2,
    output logic            wb_stall_req
);

    localparam int CW = $clog2(LOAD_DEPTH) + 1;

    wb_entry_t   in_entry;
    wb_entry_t   head;
    logic        full;
    logic        empty;
    logic [CW-1:0] count;
    logic        accept;
    logic        bypass;
    logic        push;
    logic        pop;
    scoreboard_t sb;
    scoreboard_t sb_next;
    scoreboard_t set_mask;
    scoreboard_t clr_mask;

    assign in_entry     = '{rd: load_rd, data: load_data};
    assign load_ready   = !full;
    assign wb_stall_req = (count == CW'(LOAD_DEPTH));
    assign accept       = load_valid && load_ready;
    assign pop          = !alu_valid && !empty;

`ifdef WB_LOAD_BYPASS_EN
    assign bypass = accept && empty && !alu_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && !bypass;

    wb_fifo #(
        .DEPTH (LOAD_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (in_entry),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    // Scoreboard update: retiring loads clear, newly issued loads set (set wins)
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (pop && head.rd != '0)
            clr_mask[head.rd] = 1'b1;
        if (bypass && load_rd != '0)
            clr_mask[load_rd] = 1'b1;
        if (issue_valid && issue_is_load && issue_rd != '0)
            set_mask[issue_rd] = 1'b1;
        sb_next = (sb & ~clr_mask) | set_mask;
    end

    // Scoreboard register, bit 0 hard-wired low
    always_ff @(posedge clk) begin
        if (!reset_n) sb <= '0;
        else          sb <= {sb_next[31:1], 1'b0};
    end

    assign query_busy1 = sb[query_addr1];
    assign query_busy2 = sb[query_addr2];

    // Write-port select: ALU first, then buffered load, then bypassed load
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rf_write_enable  <= 1'b0;
            rf_write_address <= '0;
            rf_write_data    <= '0;
        end else if (alu_valid) begin
            rf_write_enable  <= (alu_rd != '0);
            rf_write_address <= alu_rd;
            rf_write_data    <= alu_data;
        end else if (pop) begin
            rf_write_enable  <= (head.rd != '0);
            rf_write_address <= head.rd;
            rf_write_data    <= head.data;
        end else if (bypass) begin
            rf_write_enable  <= (load_rd != '0);
            rf_write_address <= load_rd;
            rf_write_data    <= load_data;
        end else begin
            rf_write_enable  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter.
// Directed scenarios followed by random traffic against a queue-based model.
module tb_writeback_arbiter;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        issue_valid, issue_is_load;
    logic [4:0]  issue_rd;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        load_valid, load_ready;
    logic [4:0]  load_rd;
    logic [31:0] load_data;
    logic        rf_write_enable;
    logic [4:0]  rf_write_address;
    logic [31:0] rf_write_data;
    logic [4:0]  query_addr1, query_addr2;
    logic        query_busy1, query_busy2;
    logic        wb_stall_req;

    always #5 clk = ~clk;

    writeback_arbiter #(.LOAD_DEPTH(D), .XLEN(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .issue_valid      (issue_valid),
        .issue_is_load    (issue_is_load),
        .issue_rd         (issue_rd),
        .alu_valid        (alu_valid),
        .alu_rd           (alu_rd),
        .alu_data         (alu_data),
        .load_valid       (load_valid),
        .load_ready       (load_ready),
        .load_rd          (load_rd),
        .load_data        (load_data),
        .rf_write_enable  (rf_write_enable),
        .rf_write_address (rf_write_address),
        .rf_write_data    (rf_write_data),
        .query_addr1      (query_addr1),
        .query_addr2      (query_addr2),
        .query_busy1      (query_busy1),
        .query_busy2      (query_busy2),
        .wb_stall_req     (wb_stall_req)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ment_t;

    ment_t       q[$];
    bit [31:0]   sb;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          m_rst;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset_n       = 1'b1;
        issue_valid   = 1'b0;
        issue_is_load = 1'b0;
        issue_rd      = '0;
        alu_valid     = 1'b0;
        alu_rd        = '0;
        alu_data      = '0;
        load_valid    = 1'b0;
        load_rd       = '0;
        load_data     = '0;
    endtask

    // One clock: check combinational outputs, advance model, check rf outputs
    task automatic step();
        bit    acc, byp;
        ment_t e;
        @(negedge clk);
        chk("load_ready", load_ready, (q.size() < D));
        chk("stall", wb_stall_req, (q.size() == D));
        chk("busy1", query_busy1, sb[query_addr1]);
        chk("busy2", query_busy2, sb[query_addr2]);
        acc = load_valid && (q.size() < D);
        byp = 1'b0;
`ifdef WB_LOAD_BYPASS_EN
        byp = acc && (q.size() == 0) && !alu_valid;
`endif
        m_rst = !reset_n;
        if (!reset_n) begin
            q.delete();
            sb     = '0;
            m_we   = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            if (alu_valid) begin
                m_we = (alu_rd != 0); m_addr = alu_rd; m_data = alu_data;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                m_we = (e.rd != 0); m_addr = e.rd; m_data = e.data;
                sb[e.rd] = 1'b0;
            end else if (byp) begin
                m_we = (load_rd != 0); m_addr = load_rd; m_data = load_data;
                sb[load_rd] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            if (acc && !byp) q.push_back('{rd: load_rd, data: load_data});
            if (issue_valid && issue_is_load) sb[issue_rd] = 1'b1;
            sb[0] = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("rf_we", rf_write_enable, m_we);
        if (m_we || m_rst) begin
            chk("rf_addr", rf_write_address, m_addr);
            chk("rf_data", rf_write_data, m_data);
        end
    endtask

    task automatic issue_load(input logic [4:0] rd);
        issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = rd;
    endtask

    initial begin
        idle();
        query_addr1 = '0;
        query_addr2 = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q.delete(); sb = '0; m_we = 0; m_addr = 0; m_data = 0;
        chk("rst_we", rf_write_enable, 0);
        chk("rst_addr", rf_write_address, 0);
        chk("rst_data", rf_write_data, 0);
        chk("rst_ready", load_ready, 1);
        chk("rst_stall", wb_stall_req, 0);
        reset_n = 1'b1;

        // ALU only
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        step();
        chk("alu_we", rf_write_enable, 1);
        chk("alu_addr", rf_write_address, 5);
        chk("alu_data", rf_write_data, 32'hDEADBEEF);
        idle(); step();
        chk("alu_idle_we", rf_write_enable, 0);

        // Load path
        query_addr1 = 7;
        issue_load(7); step();
        idle(); #1;
        chk("busy7_set", query_busy1, 1);
        step();
        load_valid = 1; load_rd = 7; load_data = 32'h12345678;
        step();
        idle();
`ifdef WB_LOAD_BYPASS_EN
        chk("ld_byp_we", rf_write_enable, 1);
        chk("ld_byp_data", rf_write_data, 32'h12345678);
        #1;
        chk("busy7_clr", query_busy1, 0);
        step();
`else
        chk("ld_q_we", rf_write_enable, 0);
        #1;
        chk("busy7_hold", query_busy1, 1);
        step();
        chk("ld_q_we2", rf_write_enable, 1);
        chk("ld_q_addr", rf_write_address, 7);
        chk("ld_q_data", rf_write_data, 32'h12345678);
        #1;
        chk("busy7_clr", query_busy1, 0);
`endif

        // Priority and full
        query_addr1 = 3; query_addr2 = 4;
        issue_load(3); step();
        issue_load(4); step();
        idle();
        alu_valid = 1; alu_rd = 10; alu_data = 32'hA;
        load_valid = 1; load_rd = 3; load_data = 32'h33;
        step();
        alu_rd = 11; alu_data = 32'hB;
        load_rd = 4; load_data = 32'h44;
        step();
        chk("full_ready", load_ready, 0);
        chk("full_stall", wb_stall_req, 1);
        alu_rd = 12; alu_data = 32'hC;
        load_rd = 20; load_data = 32'h99;
        step();
        idle();
        step();
        chk("ord_addr3", rf_write_address, 3);
        step();
        chk("ord_addr4", rf_write_address, 4);
        step();

        // Set/clear collision on rd 9
        query_addr1 = 9;
        issue_load(9); step();
        idle();
        alu_valid = 1; alu_rd = 1; alu_data = 32'h1;
        load_valid = 1; load_rd = 9; load_data = 32'h9;
        step();
        idle();
        issue_load(9); step();
        idle(); #1;
        chk("collide_busy9", query_busy1, 1);
        load_valid = 1; load_rd = 9; load_data = 32'h90;
        step();
        idle(); step(); step();

        // rd = 0
        query_addr1 = 0;
        issue_load(0);
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF;
        step();
        chk("rd0_alu_we", rf_write_enable, 0);
        idle();
        load_valid = 1; load_rd = 0; load_data = 32'hFFFFFFFF;
        step();
        idle(); step();
        chk("rd0_ld_we", rf_write_enable, 0);
        chk("rd0_busy", query_busy1, 0);
        chk("rd0_ready", load_ready, 1);

        // Reset mid-operation
        query_addr1 = 3; query_addr2 = 4;
        issue_load(3); step();
        issue_load(4); step();
        idle();
        alu_valid = 1; alu_rd = 13; alu_data = 32'hD;
        load_valid = 1; load_rd = 3; load_data = 32'h333;
        step();
        load_rd = 4; load_data = 32'h444;
        step();
        idle();
        reset_n = 0;
        step();
        reset_n = 1;
        chk("mrst_we", rf_write_enable, 0);
        chk("mrst_data", rf_write_data, 0);
        chk("mrst_ready", load_ready, 1);
        chk("mrst_busy3", query_busy1, 0);
        chk("mrst_busy4", query_busy2, 0);
        repeat (3) step();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            idle();
            reset_n       = ($urandom_range(0, 63) != 0);
            issue_valid   = $urandom_range(0, 1);
            issue_is_load = $urandom_range(0, 1);
            issue_rd      = 5'($urandom);
            alu_valid     = ($urandom_range(0, 2) == 0);
            alu_rd        = 5'($urandom);
            alu_data      = $urandom;
            load_valid    = $urandom_range(0, 1);
            load_rd       = 5'($urandom);
            load_data     = $urandom;
            query_addr1   = 5'($urandom);
            query_addr2   = 5'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
